// File: rtl/pc_sequencer.sv
// Next-PC unit with a circular return-address stack.
// The program counter advances only on cycles where the fetch port accepts it.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                SHIFT     = 2,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   branch_ctrl,
    input  logic                         take,
    input  logic [ADDR_W-1:0]            instr_addr,
    input  logic [ADDR_W-1:0]            reg_addr,
    input  logic [ADDR_W-1:0]            offset,
    input  logic                         fetch_ready,
    output logic [ADDR_W-1:0]            pc,
    output logic                         pc_valid,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        MODE_SEQ    = 3'b000,
        MODE_JUMP   = 3'b001,
        MODE_REG    = 3'b010,
        MODE_BRANCH = 3'b011,
        MODE_CALL   = 3'b100,
        MODE_RET    = 3'b101
    } mode_e;

    mode_e             mode;
    logic              accept;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              unf_set;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] pc_next;
    logic [PTR_W-1:0]  top;
    logic [PTR_W-1:0]  top_inc;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    assign mode    = mode_e'(branch_ctrl);
    assign accept  = pc_valid & fetch_ready;
    assign seq     = pc + (ADDR_W'(1) << SHIFT);
    assign full    = (ras_count == CNT_W'(RAS_DEPTH));
    assign empty   = (ras_count == '0);
    assign top_inc = top + PTR_W'(1);

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        pc_next = seq;
        push    = 1'b0;
        pop     = 1'b0;
        unf_set = 1'b0;
        case (mode)
            MODE_SEQ:    pc_next = seq;
            MODE_JUMP:   pc_next = instr_addr << SHIFT;
            MODE_REG:    pc_next = reg_addr << SHIFT;
            MODE_BRANCH: if (take) pc_next = pc + (offset << SHIFT);
            MODE_CALL: begin
                pc_next = instr_addr << SHIFT;
                push    = 1'b1;
            end
            MODE_RET: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    pc_next = ras_mem[top];
                    pop     = 1'b1;
                end
            end
            default:     pc_next = seq;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            pc_valid  <= 1'b0;
            ras_count <= '0;
            top       <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (accept) begin
                pc <= pc_next;
                if (push) begin
                    // A push onto a full stack wraps over the oldest entry.
                    top <= top_inc;
                    if (full) ras_ovf   <= 1'b1;
                    else      ras_count <= ras_count + CNT_W'(1);
                end
                if (pop) begin
                    top       <= top - PTR_W'(1);
                    ras_count <= ras_count - CNT_W'(1);
                end
                if (unf_set) ras_unf <= 1'b1;
            end
        end
    end

    // NOTE: the stack storage is deliberately not reset; entries are only
    // ever read below ras_count, which is reset.
    always_ff @(posedge clk) begin
        if (accept && push) ras_mem[top_inc] <= seq;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected states are queued as stimulus is
// driven, DUT snapshots are queued after each edge, and each scenario compares them.
module tb_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } state_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  branch_ctrl = '0;
    logic        take = 1'b0;
    logic [31:0] instr_addr = '0;
    logic [31:0] reg_addr = '0;
    logic [31:0] offset = '0;
    logic        fetch_ready = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    state_t sb[$];
    state_t obs[$];
    int     checks = 0;
    int     errors = 0;

    pc_sequencer #(
        .ADDR_W(32), .SHIFT(2), .RAS_DEPTH(4), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .rst(rst), .branch_ctrl(branch_ctrl), .take(take),
        .instr_addr(instr_addr), .reg_addr(reg_addr), .offset(offset),
        .fetch_ready(fetch_ready), .pc(pc), .pc_valid(pc_valid),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    function automatic string show(input state_t x);
        return $sformatf("pc=%h valid=%b cnt=%0d ovf=%b unf=%b",
                         x.pc, x.valid, x.cnt, x.ovf, x.unf);
    endfunction

    task automatic snap();
        obs.push_back('{pc, pc_valid, ras_count, ras_ovf, ras_unf});
    endtask

    task automatic expect_state(input logic [31:0] epc, input logic ev,
                                input logic [2:0] ecnt, input logic eovf, input logic eunf);
        sb.push_back('{epc, ev, ecnt, eovf, eunf});
    endtask

    // One clock: drive at the falling edge, queue the expectation, sample after the rising edge.
    task automatic cycle(input logic [2:0] ctrl, input logic tk, input logic [31:0] ia,
                         input logic [31:0] ra, input logic [31:0] off, input logic rdy,
                         input logic [31:0] epc, input logic [2:0] ecnt,
                         input logic eovf, input logic eunf);
        @(negedge clk);
        branch_ctrl = ctrl; take = tk; instr_addr = ia; reg_addr = ra;
        offset = off; fetch_ready = rdy;
        expect_state(epc, 1'b1, ecnt, eovf, eunf);
        @(posedge clk);
        #1 snap();
    endtask

    task automatic test_reset();
        state_t e, o;
        int idx = 0;
        repeat (2) @(posedge clk);
        #1 snap();
        expect_state(32'h100, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; fetch_ready = 1'b1; branch_ctrl = 3'b000;
        expect_state(32'h100, 1'b1, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 snap();
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %s, expected %s", idx, show(o), show(e));
            end
            idx++;
        end
    endtask

    task automatic test_sequential_stall();
        state_t e, o;
        int idx = 0;
        cycle(3'b000, 0, 0, 0, 0, 1, 32'h104, 0, 0, 0);
        cycle(3'b000, 0, 0, 0, 0, 1, 32'h108, 0, 0, 0);
        cycle(3'b000, 0, 0, 0, 0, 0, 32'h108, 0, 0, 0);
        cycle(3'b001, 0, 32'h999, 0, 0, 0, 32'h108, 0, 0, 0);
        cycle(3'b100, 0, 32'h40, 0, 0, 0, 32'h108, 0, 0, 0);
        cycle(3'b000, 0, 0, 0, 0, 1, 32'h10C, 0, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL seq_stall[%0d]: got %s, expected %s", idx, show(o), show(e));
            end
            idx++;
        end
    endtask

    task automatic test_jumps();
        state_t e, o;
        int idx = 0;
        cycle(3'b001, 0, 32'h40, 0, 0, 1, 32'h100, 0, 0, 0);
        cycle(3'b010, 0, 0, 32'h80, 0, 1, 32'h200, 0, 0, 0);
        cycle(3'b110, 1, 32'h7, 32'h7, 32'h7, 1, 32'h204, 0, 0, 0);
        cycle(3'b111, 1, 32'h7, 32'h7, 32'h7, 1, 32'h208, 0, 0, 0);
        cycle(3'b001, 0, 32'hC000_0001, 0, 0, 1, 32'h0000_0004, 0, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jumps[%0d]: got %s, expected %s", idx, show(o), show(e));
            end
            idx++;
        end
    endtask

    task automatic test_relative();
        state_t e, o;
        int idx = 0;
        cycle(3'b001, 0, 32'h2, 0, 0, 1, 32'h8, 0, 0, 0);
        cycle(3'b011, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0, 0, 0);
        cycle(3'b001, 0, 32'h2, 0, 0, 1, 32'h8, 0, 0, 0);
        cycle(3'b011, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'hC, 0, 0, 0);
        cycle(3'b011, 1, 0, 0, 32'h3, 1, 32'h18, 0, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL relative[%0d]: got %s, expected %s", idx, show(o), show(e));
            end
            idx++;
        end
    endtask

    task automatic test_call_return();
        state_t e, o;
        int idx = 0;
        cycle(3'b001, 0, 32'h4, 0, 0, 1, 32'h10, 0, 0, 0);
        cycle(3'b100, 0, 32'h40, 0, 0, 1, 32'h100, 1, 0, 0);
        cycle(3'b101, 0, 32'h55, 0, 0, 1, 32'h14, 0, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL call_ret[%0d]: got %s, expected %s", idx, show(o), show(e));
            end
            idx++;
        end
    endtask

    task automatic test_ras_limits();
        state_t e, o;
        int idx = 0;
        logic [31:0] a [5];
        a[0] = 32'h10;
        cycle(3'b001, 0, 32'h4, 0, 0, 1, a[0], 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            if (i < 5) a[i] = 32'h400 * i;
            cycle(3'b100, 0, 32'h100 * i, 0, 0, 1, 32'h400 * i,
                  (i > 4) ? 3'd4 : 3'(i), (i == 5), 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            cycle(3'b101, 0, 0, 0, 0, 1, a[5 - k] + 32'h4, 3'(4 - k), 1'b1, 1'b0);
        end
        cycle(3'b101, 0, 0, 0, 0, 1, 32'h408, 0, 1, 1);
        cycle(3'b000, 0, 0, 0, 0, 1, 32'h40C, 0, 1, 1);
        cycle(3'b101, 0, 0, 0, 0, 1, 32'h410, 0, 1, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ras_limits[%0d]: got %s, expected %s", idx, show(o), show(e));
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid_op();
        state_t e, o;
        int idx = 0;
        cycle(3'b100, 0, 32'h80, 0, 0, 0, 32'h410, 0, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 snap();
        expect_state(32'h100, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; branch_ctrl = 3'b000; fetch_ready = 1'b1;
        expect_state(32'h100, 1'b1, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 snap();
        @(negedge clk);
        branch_ctrl = 3'b100; instr_addr = 32'h80; fetch_ready = 1'b1;
        #2 rst = 1'b1;
        expect_state(32'h100, 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 snap();
        @(negedge clk);
        rst = 1'b0; branch_ctrl = 3'b000;
        expect_state(32'h100, 1'b1, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 snap();
        cycle(3'b101, 0, 0, 0, 0, 1, 32'h104, 0, 0, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got %s, expected %s", idx, show(o), show(e));
            end
            idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential_stall();
        test_jumps();
        test_relative();
        test_call_return();
        test_ras_limits();
        test_reset_mid_op();
        if (obs.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: %0d unmatched snapshots, expected 0", obs.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
